// File: rtl/seg_scan_pager.sv
// Multi-page, N-digit segment buffer scanned onto shared active-low seg/an lines.
// Define BLINK_EN to add per-digit blanking driven by BlinkMask/BlinkStb.
module seg_scan_pager #(
   parameter int NUM_DIGITS = 4,
   parameter int NUM_PAGES  = 4,
   parameter int SCAN_DIV   = 1000,
   localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [1:0]            Mode,
   input  logic                  Clear,
   input  logic                  WrEn,
   input  logic [PW-1:0]         WrPage,
   input  logic [DW-1:0]         WrDigit,
   input  logic [7:0]            WrData,
   input  logic                  ShiftStb,
   input  logic [7:0]            ShiftData,
   input  logic                  PageStb,
   input  logic                  HoldLast,
`ifdef BLINK_EN
   input  logic [NUM_DIGITS-1:0] BlinkMask,
   input  logic                  BlinkStb,
`endif
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic [PW-1:0]         PageIdx,
   output logic                  SeqDone
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [1:0] MODE_SHIFT = 2'd1;
   localparam logic [1:0] MODE_SEQ   = 2'd2;
   localparam logic [1:0] MODE_BLANK = 2'd3;

   logic [7:0]            buffer  [NUM_PAGES][NUM_DIGITS];
   logic [7:0]            bufNext [NUM_PAGES][NUM_DIGITS];
   logic [CW-1:0]         scanCnt;
   logic [DW-1:0]         digIdx, digNext;
   logic                  scanOn, onNext, termCnt, wasSeq, wrOk;
   logic [PW-1:0]         pageNext, pageSel;
   logic                  seqDoneNext, blankNext;
   logic [7:0]            segNext;
   logic [NUM_DIGITS-1:0] anNext;

   assign wrOk = (32'(WrPage) < NUM_PAGES) && (32'(WrDigit) < NUM_DIGITS);

   // Clear beats a write, and any write (even an ignored one) drops a shift.
   always_comb begin
      bufNext = buffer;
      if (Clear) begin
         for (int p = 0; p < NUM_PAGES; p++)
            for (int d = 0; d < NUM_DIGITS; d++)
               bufNext[p][d] = 8'hFF;
      end else if (WrEn) begin
         if (wrOk) bufNext[WrPage][WrDigit] = WrData;
      end else if (ShiftStb && (Mode == MODE_SHIFT)) begin
         for (int d = NUM_DIGITS - 1; d > 0; d--)
            bufNext[0][d] = buffer[0][d-1];
         bufNext[0][0] = ShiftData;
      end
   end

   always_comb begin
      pageNext    = PageIdx;
      seqDoneNext = 1'b0;
      if (Mode == MODE_SEQ) begin
         if (!wasSeq) begin
            pageNext = '0;
         end else if (PageStb) begin
            if (PageIdx == PW'(NUM_PAGES - 1)) begin
               if (!HoldLast) pageNext = '0;
            end else begin
               pageNext = PageIdx + 1'b1;
            end
         end
         seqDoneNext = wasSeq && HoldLast && (PageIdx == PW'(NUM_PAGES - 1));
      end
   end

   // Outputs are built from next-cycle state so seg and an always move together.
   always_comb begin
      termCnt = (scanCnt == CW'(SCAN_DIV - 1));
      onNext  = scanOn || termCnt;
      digNext = digIdx;
      if (termCnt && scanOn)
         digNext = (digIdx == DW'(NUM_DIGITS - 1)) ? '0 : digIdx + 1'b1;
      pageSel = (Mode == MODE_SEQ) ? pageNext : '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         anNext[NUM_DIGITS-1-i] = !(onNext && (32'(digNext) == i));
      segNext = (!onNext || (Mode == MODE_BLANK) || blankNext) ? 8'hFF
                                                               : bufNext[pageSel][digNext];
   end

`ifdef BLINK_EN
   logic blinkPhase, phaseNext;
   assign phaseNext = blinkPhase ^ BlinkStb;
   assign blankNext = phaseNext && BlinkMask[digNext];
   always_ff @(posedge Clk) begin
      if (Rst) blinkPhase <= 1'b0;
      else     blinkPhase <= phaseNext;
   end
`else
   assign blankNext = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int p = 0; p < NUM_PAGES; p++)
            for (int d = 0; d < NUM_DIGITS; d++)
               buffer[p][d] <= 8'hFF;
         scanCnt <= '0;
         digIdx  <= '0;
         scanOn  <= 1'b0;
         seg     <= 8'hFF;
         an      <= '1;
         PageIdx <= '0;
         SeqDone <= 1'b0;
         wasSeq  <= 1'b0;
      end else begin
         buffer  <= bufNext;
         scanCnt <= termCnt ? '0 : scanCnt + 1'b1;
         digIdx  <= digNext;
         scanOn  <= onNext;
         seg     <= segNext;
         an      <= anNext;
         PageIdx <= pageNext;
         SeqDone <= seqDoneNext;
         wasSeq  <= (Mode == MODE_SEQ);
      end
   end

endmodule

// File: tb/tb_seg_scan_pager.sv
// Directed self-checking bench for seg_scan_pager (4 digits/4 pages/div 4, plus a 3/5/2 instance).
module tb_seg_scan_pager;

   logic       Clk = 1'b0;
   logic       Rst, Clear, WrEn, WrEn2, ShiftStb, PageStb, HoldLast;
   logic [1:0] Mode, WrPage, WrDigit, WrDigit2;
   logic [2:0] WrPage2;
   logic [7:0] WrData, ShiftData;
   logic [7:0] seg, seg2;
   logic [3:0] an;
   logic [2:0] an2;
   logic [1:0] PageIdx;
   logic [2:0] PageIdx2;
   logic       SeqDone, SeqDone2;
`ifdef BLINK_EN
   logic [3:0] BlinkMask;
   logic [2:0] BlinkMask2;
   logic       BlinkStb;
`endif

   int passCnt  = 0;
   int totalCnt = 0;

   always #5 Clk = ~Clk;

   seg_scan_pager #(.NUM_DIGITS(4), .NUM_PAGES(4), .SCAN_DIV(4)) dut (
      .Clk(Clk), .Rst(Rst), .Mode(Mode), .Clear(Clear), .WrEn(WrEn),
      .WrPage(WrPage), .WrDigit(WrDigit), .WrData(WrData),
      .ShiftStb(ShiftStb), .ShiftData(ShiftData), .PageStb(PageStb), .HoldLast(HoldLast),
`ifdef BLINK_EN
      .BlinkMask(BlinkMask), .BlinkStb(BlinkStb),
`endif
      .seg(seg), .an(an), .PageIdx(PageIdx), .SeqDone(SeqDone));

   seg_scan_pager #(.NUM_DIGITS(3), .NUM_PAGES(5), .SCAN_DIV(2)) dut2 (
      .Clk(Clk), .Rst(Rst), .Mode(Mode), .Clear(Clear), .WrEn(WrEn2),
      .WrPage(WrPage2), .WrDigit(WrDigit2), .WrData(WrData),
      .ShiftStb(ShiftStb), .ShiftData(ShiftData), .PageStb(PageStb), .HoldLast(HoldLast),
`ifdef BLINK_EN
      .BlinkMask(BlinkMask2), .BlinkStb(BlinkStb),
`endif
      .seg(seg2), .an(an2), .PageIdx(PageIdx2), .SeqDone(SeqDone2));

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic wr(input logic [1:0] p, input logic [1:0] d, input logic [7:0] v);
      WrEn = 1'b1; WrPage = p; WrDigit = d; WrData = v;
      tick();
      WrEn = 1'b0;
   endtask

   task automatic wr2(input logic [2:0] p, input logic [1:0] d, input logic [7:0] v);
      WrEn2 = 1'b1; WrPage2 = p; WrDigit2 = d; WrData = v;
      tick();
      WrEn2 = 1'b0;
   endtask

   task automatic pulsePage();
      PageStb = 1'b1;
      tick();
      PageStb = 1'b0;
   endtask

   // exp packs the expected bytes as {digit3, digit2, digit1, digit0}
   task automatic scanCheck(input string tag, input logic [31:0] exp, input int n);
      logic [7:0] e;
      for (int c = 0; c < n; c++) begin
         tick();
         case (an)
            4'b0111: e = exp[7:0];
            4'b1011: e = exp[15:8];
            4'b1101: e = exp[23:16];
            4'b1110: e = exp[31:24];
            default: e = 8'hxx;
         endcase
         chk({tag, "_an"}, 32'($countones(~an)), 32'd1);
         chk({tag, "_seg"}, 32'(seg), 32'(e));
      end
   endtask

   task automatic scanCheck2(input string tag, input logic [23:0] exp, input int n);
      logic [7:0] e;
      for (int c = 0; c < n; c++) begin
         tick();
         case (an2)
            3'b011:  e = exp[7:0];
            3'b101:  e = exp[15:8];
            3'b110:  e = exp[23:16];
            default: e = 8'hxx;
         endcase
         chk({tag, "_seg2"}, 32'(seg2), 32'(e));
      end
   endtask

   task automatic waitAn(input logic [3:0] target);
      int k = 0;
      while (an !== target && k < 40) begin
         tick();
         k++;
      end
      totalCnt++;
      assert (an === target) passCnt++;
      else $error("FAIL wait_an timeout observed=%b expected=%b", an, target);
   endtask

   initial begin
      logic [3:0] anSeq [4];
      logic [1:0] expP  [5];
      anSeq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      expP  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      Rst = 1'b1; Mode = 2'd0; Clear = 1'b0; WrEn = 1'b0; WrEn2 = 1'b0;
      WrPage = '0; WrDigit = '0; WrPage2 = '0; WrDigit2 = '0; WrData = '0;
      ShiftStb = 1'b0; ShiftData = '0; PageStb = 1'b0; HoldLast = 1'b0;
`ifdef BLINK_EN
      BlinkMask = '0; BlinkMask2 = '0; BlinkStb = 1'b0;
`endif
      tick(); tick();
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_page", 32'(PageIdx), 32'd0);
      chk("rst_done", 32'(SeqDone), 32'd0);

      // scan start: dark until the first terminal count, then digit 0, every 4 cycles
      Rst = 1'b0;
      repeat (3) tick();
      chk("pre_tc_an", 32'(an), 32'hF);
      tick();
      chk("first_an", 32'(an), 32'(anSeq[0]));
      chk("first_seg", 32'(seg), 32'hFF);
      for (int k = 1; k <= 4; k++) begin
         repeat (4) tick();
         chk("cycle_an", 32'(an), 32'(anSeq[k % 4]));
         chk("cycle_seg", 32'(seg), 32'hFF);
      end

      // out-of-range writes on the 3-digit/5-page instance
      wr2(3'd0, 2'd2, 8'h12);
      wr2(3'd5, 2'd0, 8'h00);
      wr2(3'd0, 2'd3, 8'h00);
      scanCheck2("range", {8'h12, 8'hFF, 8'hFF}, 12);

      wr(2'd0, 2'd1, 8'hC7);
      scanCheck("direct", {8'hFF, 8'hFF, 8'hC7, 8'hFF}, 16);

      // shift mode
      Mode = 2'd1;
      ShiftStb = 1'b1;
      ShiftData = 8'hA4; tick();
      ShiftData = 8'hB0; tick();
      ShiftData = 8'h99; tick();
      ShiftStb = 1'b0;
      scanCheck("shift", {8'hFF, 8'hA4, 8'hB0, 8'h99}, 16);
      ShiftStb = 1'b1; ShiftData = 8'h11;
      wr(2'd0, 2'd3, 8'h88);
      ShiftStb = 1'b0;
      scanCheck("wr_vs_shift", {8'h88, 8'hA4, 8'hB0, 8'h99}, 16);

      // shift ignored outside mode 1; other pages not shown in mode 0
      Mode = 2'd0;
      ShiftStb = 1'b1; ShiftData = 8'h55; tick(); ShiftStb = 1'b0;
      wr(2'd1, 2'd0, 8'h01);
      scanCheck("mode0", {8'h88, 8'hA4, 8'hB0, 8'h99}, 16);

      // sequence mode
      wr(2'd1, 2'd0, 8'hF1);
      wr(2'd2, 2'd0, 8'hF2);
      wr(2'd3, 2'd0, 8'hF3);
      Mode = 2'd2; HoldLast = 1'b1;
      tick();
      chk("seq_entry", 32'(PageIdx), 32'd0);
      for (int i = 0; i < 5; i++) begin
         pulsePage();
         chk("seq_page", 32'(PageIdx), 32'(expP[i]));
         chk("seq_done_a", 32'(SeqDone), (i >= 3) ? 32'd1 : 32'd0);
         tick();
         chk("seq_done_b", 32'(SeqDone), (i >= 2) ? 32'd1 : 32'd0);
      end
      scanCheck("page3", {8'hFF, 8'hFF, 8'hFF, 8'hF3}, 16);
      Mode = 2'd0; tick();
      chk("leave_done", 32'(SeqDone), 32'd0);
      chk("leave_page", 32'(PageIdx), 32'd3);
      Mode = 2'd2; HoldLast = 1'b0;
      pulsePage();
      chk("reenter_page", 32'(PageIdx), 32'd0);
      chk("reenter_done", 32'(SeqDone), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         pulsePage();
         chk("wrap_page", 32'(PageIdx), 32'(i % 4));
      end
      pulsePage();
      chk("page1", 32'(PageIdx), 32'd1);
      scanCheck("page1", {8'hFF, 8'hFF, 8'hFF, 8'hF1}, 16);

      // blank mode keeps scanning
      Mode = 2'd3;
      scanCheck("blank", 32'hFFFF_FFFF, 16);
      chk("blank_page", 32'(PageIdx), 32'd1);

      // clear mid-scan
      Mode = 2'd0;
      waitAn(4'b0111);
      chk("pre_clear", 32'(seg), 32'h99);
      Clear = 1'b1; tick(); Clear = 1'b0;
      chk("clear_edge", 32'(seg), 32'hFF);
      scanCheck("clear", 32'hFFFF_FFFF, 16);

      // reset mid-slot
      wr(2'd0, 2'd0, 8'h42);
      waitAn(4'b0111);
      tick();
      chk("pre_rst", 32'(seg), 32'h42);
      Rst = 1'b1; tick();
      chk("mid_rst_an", 32'(an), 32'hF);
      chk("mid_rst_seg", 32'(seg), 32'hFF);
      chk("mid_rst_page", 32'(PageIdx), 32'd0);
      Rst = 1'b0;
      repeat (4) tick();
      chk("restart_an", 32'(an), 32'b0111);
      chk("restart_seg", 32'(seg), 32'hFF);

      wr(2'd0, 2'd0, 8'h81);
      wr(2'd0, 2'd1, 8'h82);
      wr(2'd0, 2'd2, 8'h83);
      wr(2'd0, 2'd3, 8'h84);
      scanCheck("fill", {8'h84, 8'h83, 8'h82, 8'h81}, 16);
`ifdef BLINK_EN
      BlinkMask = 4'b0001;
      BlinkStb = 1'b1; tick(); BlinkStb = 1'b0;
      scanCheck("blink_on", {8'h84, 8'h83, 8'h82, 8'hFF}, 16);
      BlinkStb = 1'b1; tick(); BlinkStb = 1'b0;
      scanCheck("blink_off", {8'h84, 8'h83, 8'h82, 8'h81}, 16);
`endif

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
